// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: mode codes, FSM states,
// mode decode and the chase-position search.
package led_pkg;

    localparam logic [3:0] MODE_MANUAL = 4'd0;
    localparam logic [3:0] MODE_BLINK  = 4'd1;
    localparam logic [3:0] MODE_CHASE  = 4'd2;
    localparam logic [3:0] MODE_DIM    = 4'd3;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_MANUAL,
        ST_BLINK,
        ST_CHASE,
        ST_DIM,
        ST_FAULT
    } led_state_t;

    // Map a mode register value to its FSM state; unknown codes fault.
    function automatic led_state_t decode_mode(input logic [3:0] mode);
        led_state_t st;
        case (mode)
            MODE_MANUAL: st = ST_MANUAL;
            MODE_BLINK:  st = ST_BLINK;
            MODE_CHASE:  st = ST_CHASE;
            MODE_DIM:    st = ST_DIM;
            default:     st = ST_FAULT;
        endcase
        return st;
    endfunction

    // Next set bit of mask above pos, wrapping 3->0. The last probe is pos
    // itself, so a single-bit mask lands on that bit; an empty mask holds pos.
    function automatic logic [1:0] chase_next(input logic [1:0] pos,
                                              input logic [3:0] mask);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = pos;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = pos + 2'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-tick prescaler: counts 0..TICK_DIV-1 and flags the last count.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 36000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running count while run; cleared on request or when stopped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || !run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: manual, blink, chase and PWM-dim patterns on four
// LEDs, with an illegal-mode fault state and a shared tick prescaler.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 36000000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [3:0] led_out_i,
    input  logic [3:0] led_mode_i,
    output logic [3:0] led_drive_o,
    output logic       tick_o,
    output logic       mode_err_o
);

    localparam int unsigned CMPW = (PWM_BITS > 4) ? PWM_BITS : 4;

    led_state_t          state;
    led_state_t          nxt_state;
    logic                change;
    logic                tick;
    logic                phase;
    logic                phase_n;
    logic [1:0]          pos;
    logic [1:0]          pos_n;
    logic [PWM_BITS-1:0] pwm;
    logic [PWM_BITS-1:0] pwm_n;
    logic [CMPW-1:0]     pwm_ext;
    logic [CMPW-1:0]     duty_ext;
    logic [3:0]          drive_n;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (change),
        .run   (nxt_state != ST_OFF),
        .tick  (tick)
    );

    assign tick_o = tick;

    // Next state, next pattern counters and the LED value they imply.
    // Outputs are derived from the next-cycle values so the registered drive
    // lines up with the state entered on the same edge; a state change
    // overrides any tick arriving in the same cycle.
    always_comb begin
        nxt_state = enable_i ? decode_mode(led_mode_i) : ST_OFF;
        change    = (nxt_state != state);
        phase_n   = phase;
        pos_n     = pos;
        pwm_n     = pwm;
        if (change || nxt_state == ST_OFF) begin
            phase_n = 1'b1;
            pos_n   = 2'd0;
            pwm_n   = '0;
        end else begin
            case (nxt_state)
                ST_BLINK: if (tick) phase_n = ~phase;
                ST_CHASE: if (tick) pos_n = chase_next(pos, led_out_i);
                ST_DIM:   pwm_n = pwm + PWM_BITS'(1);
                default:  ;
            endcase
        end

        pwm_ext  = CMPW'(pwm_n);
        duty_ext = CMPW'(led_out_i);
        drive_n  = '0;
        case (nxt_state)
            ST_MANUAL: drive_n = led_out_i;
            ST_BLINK:  drive_n = led_out_i & {4{phase_n}};
            ST_CHASE:  drive_n = led_out_i & (4'b0001 << pos_n);
            ST_DIM:    drive_n = (pwm_ext < duty_ext) ? '1 : '0;
            default:   drive_n = '0;
        endcase
    end

    // Mode FSM with its pattern counters and registered LED/error outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_OFF;
            phase       <= 1'b1;
            pos         <= 2'd0;
            pwm         <= '0;
            led_drive_o <= '0;
            mode_err_o  <= 1'b0;
        end else begin
            state       <= nxt_state;
            phase       <= phase_n;
            pos         <= pos_n;
            pwm         <= pwm_n;
            led_drive_o <= drive_n;
            mode_err_o  <= (nxt_state == ST_FAULT);
        end
    end

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 SHALL have parameter TICK_DIV, default 36000000, giving the clock cycles per pattern tick (0.5 s at 72 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter PWM_BITS, default 4, giving the width of the dimming PWM counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port enable_i, input, 1 bit: 1 runs the patterns; 0 forces the outputs dark and holds all counters at 0.
REQ-006 SHALL have port led_out_i, input, 4 bits: LED value register contents, used as a mask or a duty depending on mode.
REQ-007 SHALL have port led_mode_i, input, 4 bits: mode select (0=MANUAL, 1=BLINK, 2=CHASE, 3=DIM, 4-15=illegal).
REQ-008 SHALL have port led_drive_o, output, 4 bits: registered drive to the physical LEDs (1=on).
REQ-009 SHALL have port tick_o, output, 1 bit: one-cycle pulse on every pattern tick.
REQ-010 SHALL have port mode_err_o, output, 1 bit: registered flag, 1 while led_mode_i is illegal.

Function
REQ-011 SHALL use a prescaler counting 0..TICK_DIV-1, asserting tick_o for the one cycle the count equals TICK_DIV-1, then wrapping to 0.
REQ-012 SHALL run a mode FSM with states OFF, MANUAL, BLINK, CHASE, DIM, FAULT.
  - OFF while enable_i=0.
  - Otherwise the state is decoded from led_mode_i and taken on the next clock.
  - Illegal codes select FAULT.
REQ-013 SHALL, on any change of the FSM state, clear the prescaler, blink phase, chase position and PWM counter in the same clock edge that enters the new state.
REQ-014 SHALL in MANUAL drive led_drive_o = led_out_i, with 1-cycle latency from the input to the output.
REQ-015 SHALL in BLINK drive led_drive_o = led_out_i AND the blink phase.
  - Phase is 1 on entering BLINK.
  - Phase toggles on each tick.
REQ-016 SHALL in CHASE hold a 2-bit position pos, starting at 0 on entry, and drive the bit pos only where led_out_i[pos]=1.
  - On each tick, pos advances to the next index set in led_out_i, searching upward and wrapping 3 to 0.
  - If led_out_i=0, pos holds and the output is 0.
  - If exactly one bit is set, pos moves to that bit and stays there.
REQ-017 SHALL in DIM run a free-running PWM_BITS counter that wraps from all-ones to 0.
  - All four LEDs are driven with (counter < led_out_i, zero-extended).
  - Duty 0 gives always off; duty 15 gives 15 of every 16 cycles on.
  - A duty change takes effect on the next cycle, with no restart.
REQ-018 SHALL in FAULT drive led_drive_o=0 and mode_err_o=1.
  - mode_err_o=0 in every other state.
  - tick_o keeps running.
REQ-019 SHALL in OFF drive led_drive_o=0 and tick_o=0, and hold all counters at 0.
REQ-020 SHALL, when a tick and a mode change occur in the same cycle, let the mode change win: counters clear and the tick has no pattern effect.
REQ-021 SHALL, when led_out_i changes mid-pattern, apply the new mask or duty from the next cycle without resetting counters.

Reset
REQ-022 SHALL, on any clk edge with rst=0, apply the following reset values:
  - state OFF;
  - led_drive_o=0, tick_o=0, mode_err_o=0;
  - prescaler, pos and PWM counter = 0;
  - blink phase = 1.
REQ-023 SHALL, when rst is asserted mid-pattern, take the reset values on that edge.
  - The first post-reset state is decoded on the first edge with rst=1.

Structure
REQ-024 SHALL take the mode codes (0-3), the FSM state enum and the mode-to-state decode function from the shared package led_pkg.
REQ-025 SHALL place the prescaler in a sub-module led_tick_gen with ports clk, rst, clear, run and tick.

Verification (TICK_DIV=4, PWM_BITS=4)
REQ-026 SHALL cover reset: rst=0 for 3 cycles with mode=1 and led_out=0xF -> led_drive_o=0, tick_o=0, mode_err_o=0 every cycle.
REQ-027 SHALL cover BLINK: enable=1, mode=1, led_out=0x5 -> led_drive_o=0x5 for 4 cycles, 0x0 for 4 cycles, repeating; tick_o pulses every 4th cycle.
REQ-028 SHALL cover CHASE: mode=2, led_out=0xB -> led_drive_o sequence 0x1, 0x2, 0x8, 0x1, with each value held for 4 cycles.
  - Then led_out=0x0 -> led_drive_o=0 and pos frozen.
REQ-029 SHALL cover DIM: mode=3, led_out=0x3 -> led_drive_o=0xF for exactly 3 of every 16 cycles; led_out=0 -> 0 always.
REQ-030 SHALL cover FAULT and mode switching:
  - mode=9 -> mode_err_o=1 and led_drive_o=0 from the next cycle.
  - A switch to mode=0 in the same cycle as tick_o -> led_drive_o=led_out_i after 1 cycle, mode_err_o=0, prescaler restarted.
